// File: rtl/axi_mem_responder.sv
// Single-beat 128-bit AXI4 memory responder with fixed read and write latencies.
// It has one transaction in flight at a time, and writes take priority over reads.
module axi_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  S_AXI_awaddr,
    input  logic         S_AXI_awvalid,
    output logic         S_AXI_awready,
    input  logic [127:0] S_AXI_wdata,
    input  logic [15:0]  S_AXI_wstrb,
    input  logic         S_AXI_wvalid,
    output logic         S_AXI_wready,
    output logic [1:0]   S_AXI_bresp,
    output logic         S_AXI_bvalid,
    input  logic         S_AXI_bready,
    input  logic [31:0]  S_AXI_araddr,
    input  logic         S_AXI_arvalid,
    output logic         S_AXI_arready,
    output logic [127:0] S_AXI_rdata,
    output logic [1:0]   S_AXI_rresp,
    output logic         S_AXI_rlast,
    output logic         S_AXI_rvalid,
    input  logic         S_AXI_rready
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_LAT - 1);
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_WAIT_AW,
        S_WR_LAT,
        S_WR_RESP,
        S_RD_LAT,
        S_RD_RESP
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic aw_hs, w_hs, ar_hs;
    logic wr_fire, rd_load;

    // Address decode: the word index plus a range flag covering all upper address bits
    logic [27:0]           aw_word, ar_word;
    logic                  aw_ok, ar_ok;
    logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;

    assign aw_word = S_AXI_awaddr[31:4];
    assign ar_word = S_AXI_araddr[31:4];
    assign aw_ok   = (aw_word >> DEPTH_LOG2) == 28'd0;
    assign ar_ok   = (ar_word >> DEPTH_LOG2) == 28'd0;
    assign aw_idx  = S_AXI_awaddr[4 +: DEPTH_LOG2];
    assign ar_idx  = S_AXI_araddr[4 +: DEPTH_LOG2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_awaddr[3:0], S_AXI_araddr[3:0]};

    assign S_AXI_awready = (state_reg == S_IDLE) || (state_reg == S_WAIT_AW);
    assign S_AXI_wready  = (state_reg == S_IDLE) || (state_reg == S_WAIT_W);
    assign S_AXI_arready = (state_reg == S_IDLE) && !S_AXI_awvalid && !S_AXI_wvalid;

    assign aw_hs = S_AXI_awvalid && S_AXI_awready;
    assign w_hs  = S_AXI_wvalid && S_AXI_wready;
    assign ar_hs = S_AXI_arvalid && S_AXI_arready;

    // Captured write halves
    logic                  aw_held_reg, w_held_reg;
    logic [DEPTH_LOG2-1:0] aw_idx_reg;
    logic                  aw_ok_reg;
    logic [127:0]          w_data_reg;
    logic [15:0]           w_strb_reg;
    logic                  ar_ok_reg;

    // The write side completing this cycle comes from the bus, the other from the capture registers
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  wr_ok;
    logic [127:0]          wr_data;
    logic [15:0]           wr_strb;

    assign wr_idx  = aw_held_reg ? aw_idx_reg : aw_idx;
    assign wr_ok   = aw_held_reg ? aw_ok_reg  : aw_ok;
    assign wr_data = w_held_reg  ? w_data_reg : S_AXI_wdata;
    assign wr_strb = w_held_reg  ? w_strb_reg : S_AXI_wstrb;

    logic [1:0]   bresp_reg, rresp_reg;
    logic [127:0] rdata_reg;
    logic [127:0] rd_word_reg;
    logic [127:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_fire    = 1'b0;
        rd_load    = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                cnt_next = 4'd0;
                if (aw_hs && w_hs) begin
                    state_next = S_WR_LAT;
                    wr_fire    = 1'b1;
                end else if (aw_hs) begin
                    state_next = S_WAIT_W;
                end else if (w_hs) begin
                    state_next = S_WAIT_AW;
                end else if (ar_hs) begin
                    state_next = S_RD_LAT;
                end
            end
            S_WAIT_W: begin
                if (w_hs) begin
                    state_next = S_WR_LAT;
                    wr_fire    = 1'b1;
                end
            end
            S_WAIT_AW: begin
                if (aw_hs) begin
                    state_next = S_WR_LAT;
                    wr_fire    = 1'b1;
                end
            end
            S_WR_LAT: begin
                if (cnt_reg == WR_LAST) begin
                    state_next = S_WR_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_WR_RESP: begin
                if (S_AXI_bready) begin
                    state_next = S_IDLE;
                end
            end
            S_RD_LAT: begin
                if (cnt_reg == RD_LAST) begin
                    state_next = S_RD_RESP;
                    cnt_next   = 4'd0;
                    rd_load    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_RD_RESP: begin
                if (S_AXI_rready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bresp_reg   <= OKAY;
            rresp_reg   <= OKAY;
            rdata_reg   <= 128'd0;
        end else begin
            if (wr_fire) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bresp_reg   <= wr_ok ? OKAY : SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    aw_idx_reg  <= aw_idx;
                    aw_ok_reg   <= aw_ok;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    w_data_reg <= S_AXI_wdata;
                    w_strb_reg <= S_AXI_wstrb;
                end
            end
            if (ar_hs) begin
                ar_ok_reg <= ar_ok;
            end
            if (rd_load) begin
                rdata_reg <= ar_ok_reg ? rd_word_reg : 128'd0;
                rresp_reg <= ar_ok_reg ? OKAY : SLVERR;
            end
        end
    end

    // The RAM is never reset. Reads are registered at the AR handshake, which RD_LAT >= 1 allows.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire && wr_ok) begin
            for (int b = 0; b < 16; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (ar_hs) begin
            rd_word_reg <= mem[ar_idx];
        end
    end

    assign S_AXI_bvalid = (state_reg == S_WR_RESP);
    assign S_AXI_bresp  = bresp_reg;
    assign S_AXI_rvalid = (state_reg == S_RD_RESP);
    assign S_AXI_rlast  = (state_reg == S_RD_RESP);
    assign S_AXI_rdata  = rdata_reg;
    assign S_AXI_rresp  = rresp_reg;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array memory model
// with handshake-timing expectations.
module tb_axi_mem_responder;

    localparam int DL = 10;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam int NW = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [127:0] wdata = '0;
    logic [15:0]  wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready = 1'b0;

    axi_mem_responder #(.DEPTH_LOG2(DL), .RD_LAT(RL), .WR_LAT(WL)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_awaddr(awaddr), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
        .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
        .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rlast(rlast),
        .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
    );

    always #5 clk = ~clk;

    logic [127:0] model_mem [NW];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> 4) < (32'd1 << DL);
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                           input logic [15:0] s);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] low;
        low = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0)
            return 32'h4000 + (32'($urandom_range(0, 1023)) << 4) + low;
        return (32'($urandom_range(0, NW - 1)) << 4) | low;
    endfunction

    function automatic logic [127:0] expect_rd(input logic [31:0] a);
        return in_range(a) ? model_mem[a[6:4]] : 128'd0;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] strb,
                            input int daw, input int dw, input int db);
        bit aw_done = 0, w_done = 0, aw_now, w_now, ok;
        int cyc = 0, n = 0;
        logic [1:0] exp_resp;
        ok = in_range(addr);
        exp_resp = ok ? 2'b00 : 2'b10;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= daw;
            wvalid  = !w_done && cyc >= dw;
            #1;
            if (aw_done) check("awready_after_aw", 128'(awready), 128'(0));
            if (w_done)  check("wready_after_w", 128'(wready), 128'(0));
            if (aw_done || w_done) check("arready_in_wait", 128'(arready), 128'(0));
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        check("wr_capture_cycles", 128'(cyc), 128'((daw > dw ? daw : dw) + 1));
        if (ok) model_mem[addr[6:4]] = merge(model_mem[addr[6:4]], data, strb);
        while (!bvalid && n < 40) begin
            check("arready_wr_lat", 128'(arready), 128'(0));
            @(posedge clk); #1;
            n++;
        end
        check("b_latency", 128'(n), 128'(WL));
        check("bresp", 128'(bresp), 128'(exp_resp));
        for (int k = 0; k < db; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 128'(bvalid), 128'(1));
            check("bresp_hold", 128'(bresp), 128'(exp_resp));
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("bvalid_clear", 128'(bvalid), 128'(0));
        $display("WR addr=%h strb=%h daw=%0d dw=%0d db=%0d resp=%0d", addr, strb, daw, dw, db, bresp);
    endtask

    // Runs from just after the AR handshake edge to the R handshake
    task automatic finish_read(input logic [31:0] addr, input int dr);
        int n = 0;
        logic [127:0] exp_data;
        logic [1:0] exp_resp;
        exp_data = expect_rd(addr);
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        check("rlast_idle", 128'(rlast), 128'(0));
        while (!rvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("r_latency", 128'(n), 128'(RL));
        check("rdata", rdata, exp_data);
        check("rresp", 128'(rresp), 128'(exp_resp));
        check("rlast", 128'(rlast), 128'(1));
        for (int k = 0; k < dr; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 128'(rvalid), 128'(1));
            check("rdata_hold", rdata, exp_data);
            check("rresp_hold", 128'(rresp), 128'(exp_resp));
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("rvalid_clear", 128'(rvalid), 128'(0));
        check("rlast_clear", 128'(rlast), 128'(0));
        $display("RD addr=%h dr=%0d data=%h resp=%0d", addr, dr, exp_data, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int dar, input int dr);
        for (int k = 0; k < dar; k++) begin
            @(posedge clk); #1;
        end
        araddr = addr; arvalid = 1;
        #1;
        check("arready_idle", 128'(arready), 128'(1));
        @(posedge clk); #1;
        arvalid = 0;
        finish_read(addr, dr);
    endtask

    task automatic prio_test(input logic [31:0] addr, input logic [127:0] data);
        awaddr = addr; wdata = data; wstrb = 16'hFFFF; araddr = addr;
        awvalid = 1; wvalid = 1; arvalid = 1;
        #1;
        check("prio_arready_idle", 128'(arready), 128'(0));
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        model_mem[addr[6:4]] = data;
        for (int k = 0; k < WL + 3; k++) begin
            check("prio_arready_blocked", 128'(arready), 128'(0));
            check("prio_bvalid", 128'(bvalid), 128'(k >= WL));
            @(posedge clk); #1;
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("prio_arready_after", 128'(arready), 128'(1));
        @(posedge clk); #1;
        arvalid = 0;
        $display("PRIO write+read addr=%h", addr);
        finish_read(addr, 0);
    endtask

    task automatic reset_in_read(input logic [31:0] addr);
        araddr = addr; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("rst_rd_rvalid", 128'(rvalid), 128'(0));
        check("rst_rd_arready", 128'(arready), 128'(1));
        check("rst_rd_rlast", 128'(rlast), 128'(0));
        for (int k = 0; k < RL + 2; k++) begin
            @(posedge clk); #1;
            check("rst_rd_no_resp", 128'(rvalid), 128'(0));
        end
        $display("RST during read addr=%h", addr);
    endtask

    task automatic reset_in_wait_w(input logic [31:0] addr, input logic [127:0] data);
        awaddr = addr; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        check("wait_w_wready", 128'(wready), 128'(1));
        rst_n = 0;
        wdata = data; wstrb = 16'hFFFF; wvalid = 1;
        @(posedge clk); #1;
        rst_n = 1; wvalid = 0;
        check("rst_wr_bvalid", 128'(bvalid), 128'(0));
        check("rst_wr_awready", 128'(awready), 128'(1));
        for (int k = 0; k < WL + 2; k++) begin
            @(posedge clk); #1;
            check("rst_wr_no_resp", 128'(bvalid), 128'(0));
        end
        $display("RST during write addr=%h", addr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", 128'(bvalid), 128'(0));
        check("rst_rvalid", 128'(rvalid), 128'(0));
        check("rst_rlast", 128'(rlast), 128'(0));
        check("rst_bresp", 128'(bresp), 128'(0));
        check("rst_rresp", 128'(rresp), 128'(0));
        check("rst_rdata", rdata, 128'd0);
        check("rst_awready", 128'(awready), 128'(1));
        check("rst_wready", 128'(wready), 128'(1));
        check("rst_arready", 128'(arready), 128'(1));
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < NW; i++) do_write(32'(i) << 4, rand128(), 16'hFFFF, 0, 0, 0);

        do_write(32'h10, {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEADBEEF}, 16'h000F, 0, 0, 0);
        do_read(32'h10, 0, 0);
        do_write(32'h20, rand128(), 16'h0000, 0, 3, 0);
        do_write(32'h30, rand128(), 16'hF0F0, 2, 0, 1);
        do_read(32'h30, 0, 5);
        do_read(32'h4000, 0, 0);
        do_write(32'h4000, rand128(), 16'hFFFF, 0, 0, 0);
        do_read(32'h0, 1, 0);
        do_read(32'h20, 0, 0);
        prio_test(32'h50, rand128());
        reset_in_read(32'h60);
        do_read(32'h60, 0, 0);
        reset_in_wait_w(32'h70, rand128());
        do_write(32'h40, rand128(), 16'hFFFF, 2, 0, 0);
        do_read(32'h70, 0, 0);

        for (int t = 0; t < 60; t++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 0) begin
                logic [15:0] s;
                case ($urandom_range(0, 4))
                    0: s = 16'h0000;
                    1: s = 16'hFFFF;
                    2: s = 16'hF0F0;
                    default: s = 16'($urandom);
                endcase
                do_write(a, rand128(), s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 4));
            end
        end

        for (int i = 0; i < NW; i++) do_read(32'(i) << 4, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
